// File: rtl/p2s_pkg.sv
// Shared definitions for the parallel-to-serial display transmitter:
// FSM state encoding and a constant-width helper.
package p2s_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_LATCH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Ceiling log2 for sizing counters; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/p2s_phase_timer.sv
// Reloadable down-counter that marks the last cycle of every CLK_DIV-cycle
// phase; it restarts itself on each tick so phases run back to back.
module p2s_phase_timer
    import p2s_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tick
);

    localparam int CW = clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - CW'(1);
        if (load || tick) begin
            cnt_d = RELOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/p2s_shift_tx.sv
// Parallel-to-serial transmitter for the external D-flop display chain:
// clear the chain, shift the word out on a generated sclk, then latch it.
module p2s_shift_tx
    import p2s_pkg::*;
#(
    parameter int DATA_BITS = 64,
    parameter int CLK_DIV   = 2,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] par_data,
    output logic                 busy,
    output logic                 done,
    output logic                 sclk,
    output logic                 sdata,
    output logic                 sclr_n,
    output logic                 sload
);

    localparam int BW = clog2(DATA_BITS) + 1;

    logic [2:0]           state_q, state_d;
    logic                 phase_q, phase_d;
    logic [BW-1:0]        bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] shreg_shifted;
    logic                 cur_bit;
    logic                 tick;
    logic                 timer_load;

    logic busy_q, done_q, sclk_q, sdata_q, sclr_n_q, sload_q;
    logic busy_d, done_d, sclk_d, sdata_d, sclr_n_d, sload_d;

    generate
        if (LSB_FIRST) begin : g_lsb
            assign shreg_shifted = shreg_q >> 1;
            assign cur_bit       = shreg_d[0];
        end else begin : g_msb
            assign shreg_shifted = shreg_q << 1;
            assign cur_bit       = shreg_d[DATA_BITS-1];
        end
    endgenerate

    // Timer is held at its reload value while idle so CLEAR gets a full phase.
    assign timer_load = (state_q == ST_IDLE) || (state_q == ST_DONE);

    p2s_phase_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (timer_load),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d = par_data;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (tick) begin
                    state_d  = ST_SHIFT;
                    phase_d  = 1'b0;
                    bitcnt_d = BW'(DATA_BITS - 1);
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        // Shift on sclk fall so sdata only moves while sclk is low.
                        phase_d = 1'b0;
                        shreg_d = shreg_shifted;
                        if (bitcnt_q == '0) begin
                            state_d = ST_LATCH;
                        end else begin
                            bitcnt_d = bitcnt_q - BW'(1);
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from next state so every pin comes straight from a flop.
    always_comb begin
        busy_d   = (state_d == ST_CLEAR) || (state_d == ST_SHIFT) || (state_d == ST_LATCH);
        done_d   = (state_d == ST_DONE);
        sclr_n_d = (state_d != ST_CLEAR);
        sload_d  = (state_d == ST_LATCH);
        sclk_d   = (state_d == ST_SHIFT) && phase_d;
        sdata_d  = (state_d == ST_SHIFT) && cur_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= 1'b0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sclk_q   <= 1'b0;
            sdata_q  <= 1'b0;
            sclr_n_q <= 1'b1;
            sload_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sclk_q   <= sclk_d;
            sdata_q  <= sdata_d;
            sclr_n_q <= sclr_n_d;
            sload_q  <= sload_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign sclk   = sclk_q;
    assign sdata  = sdata_q;
    assign sclr_n = sclr_n_q;
    assign sload  = sload_q;

endmodule

// File: tb/tb_p2s_shift_tx.sv
// Bench for p2s_shift_tx: three 8-bit instances (MSB-first/CLK_DIV=2,
// LSB-first/CLK_DIV=2, MSB-first/CLK_DIV=1), each feeding a D-flop receiver chain.
module tb_p2s_shift_tx;

    logic       clk;
    logic       rst_n;
    logic [2:0] start;
    logic [7:0] par_data [3];
    logic [2:0] busy, done_w, sclk, sdata, sclr_n, sload;
    logic [2:0][7:0] rx_lat;

    int tests;
    int fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            logic [7:0] rx_sh_q;
            logic [7:0] rx_lat_q;

            p2s_shift_tx #(
                .DATA_BITS(8),
                .CLK_DIV  ((gi == 2) ? 1 : 2),
                .LSB_FIRST(gi == 1)
            ) u_dut (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (start[gi]),
                .par_data(par_data[gi]),
                .busy    (busy[gi]),
                .done    (done_w[gi]),
                .sclk    (sclk[gi]),
                .sdata   (sdata[gi]),
                .sclr_n  (sclr_n[gi]),
                .sload   (sload[gi])
            );

            // Receiver chain shifts toward the MSB on each sclk rise.
            always @(posedge sclk[gi] or negedge sclr_n[gi]) begin
                if (!sclr_n[gi]) rx_sh_q <= 8'h00;
                else             rx_sh_q <= {rx_sh_q[6:0], sdata[gi]};
            end
            always @(posedge sload[gi]) rx_lat_q <= rx_sh_q;
            assign rx_lat[gi] = rx_lat_q;
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Protocol hazards visible on the pins of instance d in the current cycle.
    function automatic int hazard(input int d, input logic prev_sdata);
        int h;
        h = 0;
        if (sclk[d] && (sdata[d] !== prev_sdata)) h = 1;
        if (!sclr_n[d] && sload[d]) h = 1;
        if (!sclr_n[d] && sclk[d]) h = 1;
        if (sload[d] && sclk[d]) h = 1;
        return h;
    endfunction

    // Reference: bit i on the wire is w[7-i] (MSB first) or w[i] (LSB first);
    // the receiver ends up holding the first bit sent in its MSB.
    function automatic logic [7:0] wire_order(input logic [7:0] w, input bit lsb);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = lsb ? w[i] : w[7-i];
        return r;
    endfunction

    task automatic run_xfer(input int d, input logic [7:0] w, input bit mid_start);
        int cd, k, busy_cnt, done_cnt, done_at, rises, clr_cnt, ld_cnt, viol;
        logic [7:0] bits;
        logic p_sclk, p_sdata;
        cd = (d == 2) ? 1 : 2;
        k  = cd * (2 * 8 + 2);
        busy_cnt = 0; done_cnt = 0; done_at = -1; rises = 0;
        clr_cnt = 0; ld_cnt = 0; viol = 0; bits = 8'h00;
        p_sclk = 1'b0; p_sdata = 1'b0;
        @(negedge clk);
        par_data[d] = w;
        start[d]    = 1'b1;
        @(posedge clk);
        #1;
        start[d]    = 1'b0;
        par_data[d] = 8'($urandom);
        for (int n = 1; n <= k + 6; n++) begin
            @(negedge clk);
            if (mid_start) begin
                if (n == cd * 6) begin
                    start[d]    = 1'b1;
                    par_data[d] = 8'h00;
                end else begin
                    start[d] = 1'b0;
                end
            end
            if (busy[d]) busy_cnt++;
            if (done_w[d]) begin
                done_cnt++;
                done_at = n;
            end
            if (sclk[d] && !p_sclk) begin
                rises++;
                bits = {bits[6:0], sdata[d]};
            end
            if (!sclr_n[d]) clr_cnt++;
            if (sload[d]) ld_cnt++;
            viol += hazard(d, p_sdata);
            p_sclk  = sclk[d];
            p_sdata = sdata[d];
        end
        start[d] = 1'b0;
        chk("busy_cycles", busy_cnt, k);
        chk("done_cycle", done_at, k + 1);
        chk("done_count", done_cnt, 1);
        chk("sclk_rises", rises, 8);
        chk("sclr_cycles", clr_cnt, cd);
        chk("sload_cycles", ld_cnt, cd);
        chk("sdata_seq", bits, wire_order(w, d == 1));
        chk("rx_latched", rx_lat[d], wire_order(w, d == 1));
        chk("hazards", viol, 0);
        $display("[TB] dut%0d word=%02h mid_start=%0d busy=%0d done@%0d bits=%02h rx=%02h",
                 d, w, mid_start, busy_cnt, done_at, bits, rx_lat[d]);
    endtask

    task automatic chk_reset_pins(input int d);
        chk("rst_busy", busy[d], 1'b0);
        chk("rst_done", done_w[d], 1'b0);
        chk("rst_sclk", sclk[d], 1'b0);
        chk("rst_sdata", sdata[d], 1'b0);
        chk("rst_sclr_n", sclr_n[d], 1'b1);
        chk("rst_sload", sload[d], 1'b0);
    endtask

    initial begin
        logic [7:0] wq [3];
        int idx, idle_at, restart_at, viol;
        logic p_sdata;
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        start = 3'b000;
        for (int i = 0; i < 3; i++) par_data[i] = 8'h00;

        #3 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk_reset_pins(d);
        $display("[TB] initial reset checked");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_xfer(0, 8'hA5, 1'b0);
        run_xfer(0, 8'($urandom), 1'b0);
        run_xfer(1, 8'h01, 1'b0);
        run_xfer(1, 8'($urandom), 1'b0);
        run_xfer(2, 8'hFF, 1'b0);
        run_xfer(2, 8'($urandom), 1'b0);
        run_xfer(0, 8'hA5, 1'b1);

        // Asynchronous reset between edges, mid-SHIFT.
        @(negedge clk);
        par_data[0] = 8'h5A;
        start[0]    = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (10) @(posedge clk);
        chk("pre_rst_busy", busy[0], 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk_reset_pins(0);
        $display("[TB] async reset mid-shift checked");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_xfer(0, 8'h3C, 1'b0);

        // Back-to-back transfers with start held high.
        for (int i = 0; i < 3; i++) wq[i] = 8'($urandom);
        idx = 0; idle_at = -1; restart_at = -1; viol = 0; p_sdata = 1'b0;
        @(negedge clk);
        par_data[0] = wq[0];
        start[0]    = 1'b1;
        for (int n = 1; n <= 3 * 40 + 10; n++) begin
            @(negedge clk);
            viol += hazard(0, p_sdata);
            p_sdata = sdata[0];
            if (n == idle_at) chk("b2b_idle", {busy[0], done_w[0]}, 2'b00);
            if (n == restart_at) chk("b2b_restart", busy[0], 1'b1);
            if (done_w[0] && idx < 3) begin
                chk("b2b_rx", rx_lat[0], wq[idx]);
                $display("[TB] b2b transfer %0d word=%02h rx=%02h at cycle %0d", idx, wq[idx], rx_lat[0], n);
                idx++;
                idle_at = n + 1;
                if (idx < 3) begin
                    restart_at  = n + 2;
                    par_data[0] = wq[idx];
                end else begin
                    start[0] = 1'b0;
                end
            end
        end
        start[0] = 1'b0;
        chk("b2b_count", idx, 3);
        chk("b2b_hazards", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
